conv_ctrl: RTL and testbench



---
 rtl/conv_ctrl_pkg.sv | 37 +++
 rtl/rc_counter.sv | 50 +++++
 rtl/conv_ctrl.sv | 138 +++++++++++++
 tb/tb_conv_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: FSM encodings, default layer geometry and error-cause codes for conv_ctrl.
// Rev 1.0
`default_nettype none

package conv_ctrl_pkg;

  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int DEF_K     = 5;

  localparam int OUT_W     = DEF_IMG_W - DEF_K + 1;
  localparam int OUT_H     = DEF_IMG_H - DEF_K + 1;
  localparam int OUT_TOTAL = OUT_W * OUT_H;
  localparam int N_W       = DEF_K * DEF_K;
  localparam int CNT_W     = $clog2(OUT_TOTAL + 1);
  localparam int WCNT_W    = $clog2(N_W + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_W = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_OVF        = 2'd1,
    ERR_STRAY      = 2'd2,
    ERR_EARLY_DONE = 2'd3
  } err_cause_e;

  function automatic int out_total(input int w, input int h, input int k);
    return (w - k + 1) * (h - k + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rc_counter.sv
// rc_counter: raster col/row counter with wrap, last-pixel and valid-window flags.
// Rev 1.0
`default_nettype none

module rc_counter
  import conv_ctrl_pkg::*;
#(
  parameter int W = DEF_IMG_W,
  parameter int H = DEF_IMG_H,
  parameter int K = DEF_K
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic last,
  output logic win_valid
);

  localparam int CB = $clog2(W + 1);
  localparam int RB = $clog2(H + 1);
  localparam logic [CB-1:0] COL_MAX = CB'(W - 1);
  localparam logic [CB-1:0] COL_WIN = CB'(K - 1);
  localparam logic [RB-1:0] ROW_MAX = RB'(H - 1);
  localparam logic [RB-1:0] ROW_WIN = RB'(K - 1);

  logic [CB-1:0] col;
  logic [RB-1:0] row;

  // Flags describe the pixel being accepted this cycle, before the advance.
  assign last      = (row == ROW_MAX) && (col == COL_MAX);
  assign win_valid = (row >= ROW_WIN) && (col >= COL_WIN);

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_ctrl.sv
// conv_ctrl: sequences kernel load, image streaming and result counting for one binary conv layer.
// Rev 1.0
`default_nettype none

module conv_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int K     = DEF_K
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_start,
  output logic       cmd_ready,
  input  logic       cmd_abort,
  input  logic       wt_valid,
  output logic       wt_ready,
  input  logic       wt_bit,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] pix_data,
  output logic       win_start,
  output logic [7:0] win_din,
  output logic       state,
  output logic       conv_start,
  output logic       conv_weight_en,
  output logic       conv_weight,
  input  logic       conv_ovalid,
  input  logic       conv_done,
  output logic [$clog2(out_total(IMG_W, IMG_H, K) + 1)-1:0] out_cnt,
  output logic       layer_done,
  output logic       err
);

  localparam int TOTAL = out_total(IMG_W, IMG_H, K);
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int NWT   = K * K;
  localparam int WW    = $clog2(NWT + 1);
  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
  localparam logic [WW-1:0] WLAST_C = WW'(NWT - 1);

  logic [2:0]    fsm;
  logic [WW-1:0] wcnt;
  logic [CW-1:0] cnt_next;
  logic          wt_fire, pix_fire, rc_clr, raster_last, raster_win, cnt_full, in_run;
  err_cause_e    cause;

  assign cmd_ready  = (fsm == ST_IDLE);
  assign wt_ready   = (fsm == ST_LOAD_W);
  assign pix_ready  = (fsm == ST_STREAM);
  assign layer_done = (fsm == ST_DONE);
  assign in_run     = (fsm == ST_STREAM) || (fsm == ST_DRAIN);
  assign cnt_full   = (out_cnt == TOTAL_C);

  // Abort wins over any handshake presented in the same cycle.
  assign wt_fire  = wt_valid && wt_ready && !cmd_abort;
  assign pix_fire = pix_valid && pix_ready && !cmd_abort;
  assign rc_clr   = cmd_abort || (cmd_ready && cmd_start);

  rc_counter #(.W(IMG_W), .H(IMG_H), .K(K)) u_raster (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (rc_clr),
    .en        (pix_fire),
    .last      (raster_last),
    .win_valid (raster_win)
  );

  always_comb begin
    cnt_next = out_cnt;
    if (conv_ovalid && in_run && !cnt_full) cnt_next = out_cnt + 1'b1;
  end

  always_comb begin
    cause = ERR_NONE;
    if (conv_ovalid && !in_run)      cause = ERR_STRAY;
    else if (conv_ovalid && cnt_full) cause = ERR_OVF;
    else if (conv_done && !cnt_full)  cause = ERR_EARLY_DONE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fsm            <= ST_IDLE;
      wcnt           <= '0;
      out_cnt        <= '0;
      err            <= 1'b0;
      win_start      <= 1'b0;
      win_din        <= '0;
      state          <= 1'b0;
      conv_start     <= 1'b0;
      conv_weight_en <= 1'b0;
      conv_weight    <= 1'b0;
    end else begin
      win_start      <= pix_fire;
      conv_weight_en <= wt_fire;
      conv_start     <= 1'b0;
      state          <= pix_fire && raster_win;
      if (pix_fire) win_din     <= pix_data;
      if (wt_fire)  conv_weight <= wt_bit;

      // out_cnt and err are frozen on abort so they can be inspected afterwards.
      if (cmd_abort) begin
        fsm  <= ST_IDLE;
        wcnt <= '0;
      end else begin
        out_cnt <= cnt_next;
        if (cause != ERR_NONE) err <= 1'b1;
        case (fsm)
          ST_IDLE: begin
            if (cmd_start) begin
              fsm     <= ST_LOAD_W;
              wcnt    <= '0;
              out_cnt <= '0;
              err     <= 1'b0;
            end
          end
          ST_LOAD_W: begin
            if (wt_fire) begin
              wcnt <= wcnt + 1'b1;
              if (wcnt == WLAST_C) begin
                fsm        <= ST_STREAM;
                conv_start <= 1'b1;
              end
            end
          end
          ST_STREAM: if (pix_fire && raster_last) fsm <= ST_DRAIN;
          ST_DRAIN:  if (cnt_next == TOTAL_C) fsm <= ST_DONE;
          ST_DONE:   fsm <= ST_IDLE;
          default:   fsm <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: directed self-checking bench for conv_ctrl at 28x28/K=5 and 3x3/K=3.
// Rev 1.0
`default_nettype none

module tb_conv_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, cmd_start, cmd_abort, wt_valid, wt_bit, pix_valid, conv_ovalid, conv_done;
  logic [7:0] pix_data;
  logic       cmd_ready, wt_ready, pix_ready, win_start, state, conv_start;
  logic       conv_weight_en, conv_weight, layer_done, err;
  logic [7:0] win_din;
  logic [9:0] out_cnt;

  logic       s_cmd_start, s_cmd_abort, s_wt_valid, s_wt_bit, s_pix_valid, s_conv_ovalid, s_conv_done;
  logic [7:0] s_pix_data;
  logic       s_cmd_ready, s_wt_ready, s_pix_ready, s_win_start, s_state, s_conv_start;
  logic       s_conv_weight_en, s_conv_weight, s_layer_done, s_err;
  logic [7:0] s_win_din;
  logic [0:0] s_out_cnt;

  conv_ctrl dut (
    .clk(clk), .rstn(rstn), .cmd_start(cmd_start), .cmd_ready(cmd_ready), .cmd_abort(cmd_abort),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_bit(wt_bit),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .win_start(win_start), .win_din(win_din), .state(state), .conv_start(conv_start),
    .conv_weight_en(conv_weight_en), .conv_weight(conv_weight),
    .conv_ovalid(conv_ovalid), .conv_done(conv_done), .out_cnt(out_cnt),
    .layer_done(layer_done), .err(err)
  );

  conv_ctrl #(.IMG_W(3), .IMG_H(3), .K(3)) dut_s (
    .clk(clk), .rstn(rstn), .cmd_start(s_cmd_start), .cmd_ready(s_cmd_ready), .cmd_abort(s_cmd_abort),
    .wt_valid(s_wt_valid), .wt_ready(s_wt_ready), .wt_bit(s_wt_bit),
    .pix_valid(s_pix_valid), .pix_ready(s_pix_ready), .pix_data(s_pix_data),
    .win_start(s_win_start), .win_din(s_win_din), .state(s_state), .conv_start(s_conv_start),
    .conv_weight_en(s_conv_weight_en), .conv_weight(s_conv_weight),
    .conv_ovalid(s_conv_ovalid), .conv_done(s_conv_done), .out_cnt(s_out_cnt),
    .layer_done(s_layer_done), .err(s_err)
  );

  int checks = 0;
  int errors = 0;
  logic [24:0] wpat = 25'h15A3C7E;

  // Strobe monitor for the default-size instance
  logic       mon_clr = 1'b1;
  int         n_wen, n_cst, n_win, n_st1, first_st, n_done, n_bad, pidx;
  logic       p_wfire = 1'b0, p_pfire = 1'b0, p_wbit = 1'b0;
  logic [7:0] p_pdata = 8'd0;

  function automatic logic exp_flag(input int i);
    return ((i / 28) >= 4) && ((i % 28) >= 4);
  endfunction

  always @(posedge clk) begin
    if (mon_clr) begin
      n_wen <= 0; n_cst <= 0; n_win <= 0; n_st1 <= 0;
      first_st <= -1; n_done <= 0; n_bad <= 0; pidx <= 0;
    end else begin
      n_wen  <= n_wen + int'(conv_weight_en);
      n_cst  <= n_cst + int'(conv_start);
      n_done <= n_done + int'(layer_done);
      n_bad  <= n_bad + int'(win_start !== p_pfire) + int'(conv_weight_en !== p_wfire)
              + int'(conv_start && !(conv_weight_en && pix_ready))
              + int'(conv_weight_en && (conv_weight !== p_wbit))
              + int'(win_start && ((win_din !== p_pdata) || (state !== exp_flag(pidx))));
      if (win_start) begin
        n_win <= n_win + 1;
        pidx  <= pidx + 1;
        if (state) begin
          n_st1 <= n_st1 + 1;
          if (first_st < 0) first_st <= pidx;
        end
      end
    end
    p_wfire <= rstn && !cmd_abort && wt_valid && wt_ready;
    p_pfire <= rstn && !cmd_abort && pix_valid && pix_ready;
    p_wbit  <= wt_bit;
    p_pdata <= pix_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_wt_ready"},  32'(wt_ready), 0);
    chk({tag, "_pix_ready"}, 32'(pix_ready), 0);
    chk({tag, "_win_start"}, 32'(win_start), 0);
    chk({tag, "_win_din"},   32'(win_din), 0);
    chk({tag, "_state"},     32'(state), 0);
    chk({tag, "_conv_start"}, 32'(conv_start), 0);
    chk({tag, "_wen"},       32'(conv_weight_en), 0);
    chk({tag, "_weight"},    32'(conv_weight), 0);
    chk({tag, "_out_cnt"},   32'(out_cnt), 0);
    chk({tag, "_layer_done"}, 32'(layer_done), 0);
    chk({tag, "_err"},       32'(err), 0);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1; cyc(); mon_clr = 1'b0;
  endtask

  task automatic start_layer(input string tag);
    cmd_start = 1'b1; cyc(); cmd_start = 1'b0;
    chk({tag, "_wt_ready"}, 32'(wt_ready), 1);
    chk({tag, "_clr_cnt"},  32'(out_cnt), 0);
    chk({tag, "_clr_err"},  32'(err), 0);
  endtask

  task automatic send_weights(input int gap, input string tag);
    for (int i = 0; i < 25; i++) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        wt_valid = 1'b0; cyc();
      end
      wt_valid = 1'b1; wt_bit = wpat[i]; cyc();
    end
    wt_valid = 1'b0;
    chk({tag, "_conv_start"}, 32'(conv_start), 1);
    chk({tag, "_pix_ready"},  32'(pix_ready), 1);
  endtask

  task automatic send_pixels(input int gap, input int n_ov, input int n_pix);
    for (int i = 0; i < n_pix; i++) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        pix_valid = 1'b0; conv_ovalid = 1'b0; cyc();
      end
      pix_valid = 1'b1; pix_data = 8'(i * 7 + 3); conv_ovalid = (i < n_ov); cyc();
    end
    pix_valid = 1'b0; conv_ovalid = 1'b0;
  endtask

  task automatic drain(input int n, input int lat, input string tag);
    int k = 0;
    for (int i = 0; i < n; i++) begin
      conv_ovalid = 1'b1; cyc();
    end
    conv_ovalid = 1'b0;
    while (!layer_done && k < 8) begin
      cyc(); k++;
    end
    chk({tag, "_layer_done"}, 32'(layer_done), 1);
    chk({tag, "_done_lat"}, 32'(k), 32'(lat));
    cyc();
    chk({tag, "_back_idle"}, 32'(cmd_ready), 1);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_n_wen"},  32'(n_wen), 25);
    chk({tag, "_n_cst"},  32'(n_cst), 1);
    chk({tag, "_n_win"},  32'(n_win), 784);
    chk({tag, "_n_st1"},  32'(n_st1), 576);
    chk({tag, "_first"},  32'(first_st), 116);
    chk({tag, "_n_done"}, 32'(n_done), 1);
    chk({tag, "_bad"},    32'(n_bad), 0);
    chk({tag, "_out_cnt"}, 32'(out_cnt), 576);
    chk({tag, "_err"},    32'(err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0; wt_valid = 1'b0; wt_bit = 1'b0;
    pix_valid = 1'b0; pix_data = 8'd0; conv_ovalid = 1'b0; conv_done = 1'b0;
    s_cmd_start = 1'b0; s_cmd_abort = 1'b0; s_wt_valid = 1'b0; s_wt_bit = 1'b0;
    s_pix_valid = 1'b0; s_pix_data = 8'd0; s_conv_ovalid = 1'b0; s_conv_done = 1'b0;
    cyc(); cyc();
    chk_reset_outputs("rst");
    chk("s_rst_cmd_ready", 32'(s_cmd_ready), 1);
    rstn = 1'b1;

    // Small 3x3/K=3 layer: one valid window, ovalid on DRAIN entry
    s_cmd_start = 1'b1; cyc(); s_cmd_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_wt_valid = 1'b1; s_wt_bit = wpat[i]; cyc();
    end
    s_wt_valid = 1'b0;
    chk("s_conv_start", 32'(s_conv_start), 1);
    for (int i = 0; i < 9; i++) begin
      s_pix_valid = 1'b1; s_pix_data = 8'(i + 1); cyc();
      chk("s_win_start", 32'(s_win_start), 1);
      chk("s_state", 32'(s_state), (i == 8) ? 1 : 0);
    end
    s_pix_valid = 1'b0;
    chk("s_in_drain", 32'(s_pix_ready | s_cmd_ready | s_layer_done), 0);
    s_conv_ovalid = 1'b1; cyc(); s_conv_ovalid = 1'b0;
    chk("s_layer_done", 32'(s_layer_done), 1);
    chk("s_out_cnt", 32'(s_out_cnt), 1);
    chk("s_err", 32'(s_err), 0);
    cyc();
    chk("s_idle", 32'(s_cmd_ready), 1);

    // Nominal layer, full throughput
    clear_mon();
    start_layer("nom");
    send_weights(0, "nom");
    send_pixels(0, 0, 784);
    chk("nom_drain_pix_ready", 32'(pix_ready), 0);
    drain(576, 0, "nom");
    chk_counts("nom");

    // Same layer with ~30% idle on both streams
    clear_mon();
    start_layer("gap");
    send_weights(30, "gap");
    send_pixels(30, 0, 784);
    drain(576, 0, "gap");
    chk_counts("gap");

    // Abort while pixel 300 is offered
    clear_mon();
    start_layer("abt");
    send_weights(0, "abt");
    send_pixels(0, 10, 300);
    pix_valid = 1'b1; pix_data = 8'hEE; cmd_abort = 1'b1; cyc();
    cmd_abort = 1'b0; pix_valid = 1'b0;
    chk("abt_cmd_ready", 32'(cmd_ready), 1);
    chk("abt_win_start", 32'(win_start), 0);
    cyc(); cyc(); cyc();
    chk("abt_n_win", 32'(n_win), 300);
    chk("abt_out_cnt_held", 32'(out_cnt), 10);
    chk("abt_bad", 32'(n_bad), 0);
    clear_mon();
    start_layer("post_abt");
    send_weights(0, "post_abt");
    send_pixels(0, 0, 784);
    drain(576, 0, "post_abt");
    chk_counts("post_abt");

    // Early conv_done at out_cnt=100
    start_layer("edone");
    send_weights(0, "edone");
    send_pixels(0, 0, 784);
    conv_ovalid = 1'b1;
    for (int i = 0; i < 100; i++) cyc();
    conv_ovalid = 1'b0; conv_done = 1'b1; cyc(); conv_done = 1'b0;
    chk("edone_err", 32'(err), 1);
    chk("edone_out_cnt", 32'(out_cnt), 100);
    chk("edone_still_drain", 32'(cmd_ready | pix_ready | layer_done), 0);
    drain(476, 0, "edone");

    // 577 results: the extra one saturates and flags
    start_layer("ovf");
    send_weights(0, "ovf");
    send_pixels(0, 577, 784);
    chk("ovf_out_cnt", 32'(out_cnt), 576);
    chk("ovf_err", 32'(err), 1);
    drain(0, 1, "ovf");

    // Reset pulse mid-LOAD_W, restart on the next cycle
    start_layer("rl");
    for (int i = 0; i < 10; i++) begin
      wt_valid = 1'b1; wt_bit = 1'b1; conv_ovalid = (i == 4); cyc();
    end
    conv_ovalid = 1'b0;
    chk("rl_pre_err", 32'(err), 1);
    rstn = 1'b0; mon_clr = 1'b1; cyc();
    wt_valid = 1'b0; rstn = 1'b1; mon_clr = 1'b0;
    chk_reset_outputs("rl");
    cmd_start = 1'b1; cyc(); cmd_start = 1'b0;
    chk("rl_restart_wt_ready", 32'(wt_ready), 1);
    chk("rl_restart_cmd_ready", 32'(cmd_ready), 0);
    send_weights(0, "rl");
    send_pixels(0, 0, 784);
    drain(576, 0, "rl");
    chk_counts("rl");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
